mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath width in bits; SHALL be a multiple of 32, legal values 32 and 64.
REQ-002 Parameter OFF_W, default $clog2(DATA_W/8), byte-offset bits taken from the low bits of aluout.
REQ-003 CLOCK  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream holds a valid instruction.
REQ-006 in_ready  output  1  block accepts an instruction this cycle.
REQ-007 instruction  input  32  MIPS instruction word.
REQ-008 aluout  input  DATA_W signed  ALU result or effective address.
REQ-009 mem_req  output  1  memory access request, one-cycle pulse.
REQ-010 mem_we  output  1  request is a store; valid only with mem_req.
REQ-011 mem_rvalid  input  1  memory response or store acknowledge; memdata is valid on loads.
REQ-012 memdata  input  DATA_W  memory read word.
REQ-013 flush  input  1  kill the instruction held in this stage.
REQ-014 out_valid  output  1  write-back bundle valid.
REQ-015 out_ready  input  1  downstream accepts the bundle.
REQ-016 aluoutM  output  DATA_W signed  selected write-back data.
REQ-017 instructionM  output  32  registered instruction.
REQ-018 wb_en  output  1  write-back enabled; high only for loads and non-memory instructions.
REQ-019 misalign  output  1  registered flag for a misaligned halfword or word access.

Function
REQ-020 States SHALL be IDLE, WAIT, DRAIN and HOLD; in_ready SHALL equal (state==IDLE).
REQ-021 IDLE, in_valid, opcode in {lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101, sw 101011}, aligned: the block SHALL latch instruction/aluout, pulse mem_req (mem_we=1 for sw) on the accept cycle, and go to WAIT.
REQ-022 IDLE, in_valid, any other opcode: the block SHALL latch, set aluoutM=aluout and wb_en=1, and go to HOLD next cycle, with no mem_req.
REQ-023 Misaligned access (lh/lhu with aluout[0]=1; lw with aluout[1:0]!=0): the block SHALL issue no mem_req, set misalign=1, aluoutM=0, wb_en=0, and go to HOLD.
REQ-024 In WAIT, mem_rvalid SHALL cause the result to be formed from memdata in the same cycle, registered, and the state to go to HOLD.
REQ-025 Lane select: byte lane = aluout[OFF_W-1:0]; halfword lane = aluout[OFF_W-1:1]; word lane = aluout[OFF_W-1:2].
REQ-026 Load result extension: lb and lh SHALL sign-extend and lbu and lhu SHALL zero-extend to DATA_W; lw SHALL sign-extend when DATA_W=64.
REQ-027 On sw, aluoutM SHALL equal the latched aluout, with wb_en=0.
REQ-028 HOLD SHALL assert out_valid with stable outputs until out_ready=1, then go to IDLE.
REQ-029 Minimum latency: a non-memory instruction accepted in cycle N SHALL produce out_valid in cycle N+1; a load SHALL produce out_valid one cycle after mem_rvalid.
REQ-030 flush in HOLD SHALL drop out_valid and go to IDLE.
REQ-031 flush in WAIT SHALL go to DRAIN; DRAIN SHALL consume the next mem_rvalid silently and then go to IDLE, with no out_valid.
REQ-032 flush in IDLE SHALL block acceptance in that cycle.
REQ-033 flush together with mem_rvalid in WAIT SHALL go to IDLE and discard the data.
REQ-034 mem_rvalid arriving in IDLE or HOLD SHALL be ignored.
REQ-035 Only one memory request SHALL be outstanding at any time.

Reset
REQ-036 RESET=1 SHALL force IDLE asynchronously, with out_valid, mem_req, mem_we, wb_en and misalign at 0 and aluoutM and instructionM at 0.
REQ-037 Reset during WAIT or DRAIN SHALL abandon the outstanding access; a later mem_rvalid SHALL be ignored per REQ-034.
REQ-038 First acceptance SHALL be possible in the first cycle after RESET deasserts.

Verification
REQ-039 add (op 000000), aluout=0x0000_0005, out_ready=1 -> out_valid next cycle, aluoutM=5, wb_en=1, no mem_req.
REQ-040 lb, aluout=...01, memdata=0x1234_80FF, rvalid after 3 cycles -> aluoutM=0xFFFF_FF80.
REQ-041 lbu on the same data -> aluoutM=0x0000_0080; lhu with aluout[1:0]=2 -> 0x0000_1234.
REQ-042 lw with aluout=...02 -> no mem_req, misalign=1, aluoutM=0, wb_en=0.
REQ-043 lw, flush in WAIT, then rvalid -> no out_valid, in_ready=1 one cycle after rvalid.
REQ-044 HOLD with out_ready=0 for 4 cycles, then 1 -> outputs stable for all 5 cycles; RESET pulsed mid-WAIT -> IDLE immediately.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory / write-back pipeline stage for a MIPS-style core.
// Issues at most one memory request per instruction, forms load results from
// the returned word (lane select plus sign/zero extension) and presents a
// registered write-back bundle under a valid/ready handshake.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [31:0]              instruction_i,
  input  logic signed [DATA_W-1:0] aluout_i,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  input  logic                     mem_rvalid_i,
  input  logic [DATA_W-1:0]        memdata_i,
  input  logic                     flush_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic signed [DATA_W-1:0] aluoutM_o,
  output logic [31:0]              instructionM_o,
  output logic                     wb_en_o,
  output logic                     misalign_o
);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN, HOLD} state_e;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SW  = 6'b101011;

  state_e                     state_q, state_d;
  logic [31:0]                instr_q, instr_d;
  logic [OFF_W-1:0]           off_q, off_d;
  logic signed [DATA_W-1:0]   result_q, result_d;
  logic                       wb_en_q, wb_en_d;
  logic                       misalign_q, misalign_d;

  logic [5:0]                 op_in, op_q;
  logic                       is_mem_in, is_store_in, misaligned_in, accept;
  logic [OFF_W-1:0]           off_sel;
  logic [DATA_W-1:0]          shifted;
  logic signed [DATA_W-1:0]   load_data;

  assign op_in = instruction_i[31:26];
  assign op_q  = instr_q[31:26];

  assign is_mem_in   = (op_in == OP_LB) || (op_in == OP_LH) || (op_in == OP_LW) ||
                       (op_in == OP_LBU) || (op_in == OP_LHU) || (op_in == OP_SW);
  assign is_store_in = (op_in == OP_SW);
  assign misaligned_in = (((op_in == OP_LH) || (op_in == OP_LHU)) && aluout_i[0]) ||
                         ((op_in == OP_LW) && (aluout_i[1:0] != 2'b00));

  // Acceptance is blocked by flush; reset gates the combinational request so
  // nothing leaks out while the state register is being held in IDLE.
  assign accept = (state_q == IDLE) && in_valid_i && !flush_i;

  assign in_ready_o     = (state_q == IDLE);
  assign mem_req_o      = accept && is_mem_in && !misaligned_in && !rst_i;
  assign mem_we_o       = mem_req_o && is_store_in;
  assign out_valid_o    = (state_q == HOLD);
  assign aluoutM_o      = result_q;
  assign instructionM_o = instr_q;
  assign wb_en_o        = wb_en_q;
  assign misalign_o     = misalign_q;

  // Select the byte offset of the lane, then shift the lane down to bit 0.
  // Masking the offset (rather than slicing it) keeps word lanes legal when
  // DATA_W=32 and the word lane field is empty.
  always_comb begin
    off_sel = off_q;
    case (op_q)
      OP_LH, OP_LHU: off_sel = off_q & ~OFF_W'(1);
      OP_LW:         off_sel = off_q & ~OFF_W'(3);
      default:       off_sel = off_q;
    endcase
    shifted = memdata_i >> {off_sel, 3'b000};
  end

  // Extend the selected lane; stores keep the latched address as their result.
  always_comb begin
    load_data = result_q;
    case (op_q)
      OP_LB:   load_data = DATA_W'(signed'(shifted[7:0]));
      OP_LBU:  load_data = DATA_W'(shifted[7:0]);
      OP_LH:   load_data = DATA_W'(signed'(shifted[15:0]));
      OP_LHU:  load_data = DATA_W'(shifted[15:0]);
      OP_LW:   load_data = DATA_W'(signed'(shifted[31:0]));
      default: load_data = result_q;
    endcase
  end

  // Next-state and datapath update for the four-state handshake controller.
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    off_d      = off_q;
    result_d   = result_q;
    wb_en_d    = wb_en_q;
    misalign_d = misalign_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          instr_d = instruction_i;
          off_d   = aluout_i[OFF_W-1:0];
          if (is_mem_in && misaligned_in) begin
            misalign_d = 1'b1;
            result_d   = '0;
            wb_en_d    = 1'b0;
            state_d    = HOLD;
          end else if (is_mem_in) begin
            misalign_d = 1'b0;
            result_d   = aluout_i;
            wb_en_d    = 1'b0;
            state_d    = WAIT;
          end else begin
            misalign_d = 1'b0;
            result_d   = aluout_i;
            wb_en_d    = 1'b1;
            state_d    = HOLD;
          end
        end
      end
      WAIT: begin
        if (flush_i && mem_rvalid_i) begin
          state_d = IDLE;
        end else if (flush_i) begin
          state_d = DRAIN;
        end else if (mem_rvalid_i) begin
          result_d = load_data;
          wb_en_d  = (op_q != OP_SW);
          state_d  = HOLD;
        end
      end
      DRAIN: begin
        if (mem_rvalid_i) state_d = IDLE;
      end
      HOLD: begin
        if (flush_i || out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and write-back bundle registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      instr_q    <= '0;
      off_q      <= '0;
      result_q   <= '0;
      wb_en_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      off_q      <= off_d;
      result_q   <= result_d;
      wb_en_q    <= wb_en_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage (DATA_W=32); inputs change on the falling
// edge and outputs are sampled 1ns later.
module tb_mem_wb_stage;

  logic               clk, rst;
  logic               in_valid, in_ready;
  logic [31:0]        instruction;
  logic signed [31:0] aluout;
  logic               mem_req, mem_we, mem_rvalid;
  logic [31:0]        memdata;
  logic               flush, out_valid, out_ready;
  logic signed [31:0] aluoutM;
  logic [31:0]        instructionM;
  logic               wb_en, misalign;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] I_ADD = {6'b000000, 26'h0012820};
  localparam logic [31:0] I_LB  = {6'b100000, 26'h0221000};
  localparam logic [31:0] I_LH  = {6'b100001, 26'h0221001};
  localparam logic [31:0] I_LW  = {6'b100011, 26'h0221002};
  localparam logic [31:0] I_LBU = {6'b100100, 26'h0221003};
  localparam logic [31:0] I_LHU = {6'b100101, 26'h0221004};
  localparam logic [31:0] I_SW  = {6'b101011, 26'h0221005};

  mem_wb_stage #(.DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instruction_i(instruction), .aluout_i(aluout),
    .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_rvalid_i(mem_rvalid), .memdata_i(memdata),
    .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .aluoutM_o(aluoutM), .instructionM_o(instructionM),
    .wb_en_o(wb_en), .misalign_o(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  // Non-memory instruction: result visible the cycle after acceptance.
  task automatic alu_op(input string tag, input logic [31:0] ins, input logic [31:0] a);
    in_valid = 1'b1; instruction = ins; aluout = a; out_ready = 1'b1;
    #1;
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, " mem_req"}, 32'(mem_req), 32'd0);
    nxt(); in_valid = 1'b0;
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " aluoutM"}, aluoutM, a);
    chk({tag, " wb_en"}, 32'(wb_en), 32'd1);
    chk({tag, " instrM"}, instructionM, ins);
    nxt();
    chk({tag, " back idle"}, 32'(out_valid), 32'd0);
  endtask

  // Aligned memory op, response three cycles after acceptance.
  task automatic mem_op(input string tag, input logic [31:0] ins, input logic [31:0] a,
                        input logic [31:0] d, input logic we,
                        input logic [31:0] exp_res, input logic exp_wb);
    in_valid = 1'b1; instruction = ins; aluout = a; out_ready = 1'b1;
    #1;
    chk({tag, " mem_req"}, 32'(mem_req), 32'd1);
    chk({tag, " mem_we"}, 32'(mem_we), 32'(we));
    nxt(); in_valid = 1'b0;
    chk({tag, " wait busy"}, 32'(in_ready), 32'd0);
    chk({tag, " req pulse"}, 32'(mem_req), 32'd0);
    nxt();
    chk({tag, " no early valid"}, 32'(out_valid), 32'd0);
    nxt(); mem_rvalid = 1'b1; memdata = d;
    nxt(); mem_rvalid = 1'b0; memdata = 32'hDEAD_BEEF;
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " aluoutM"}, aluoutM, exp_res);
    chk({tag, " wb_en"}, 32'(wb_en), 32'(exp_wb));
    chk({tag, " misalign"}, 32'(misalign), 32'd0);
    nxt();
    chk({tag, " back idle"}, 32'(in_ready), 32'd1);
  endtask

  // Misaligned access: no request, zeroed result, flagged.
  task automatic mis_op(input string tag, input logic [31:0] ins, input logic [31:0] a);
    in_valid = 1'b1; instruction = ins; aluout = a; out_ready = 1'b1;
    #1;
    chk({tag, " no mem_req"}, 32'(mem_req), 32'd0);
    nxt(); in_valid = 1'b0;
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " misalign"}, 32'(misalign), 32'd1);
    chk({tag, " aluoutM"}, aluoutM, 32'd0);
    chk({tag, " wb_en"}, 32'(wb_en), 32'd0);
    nxt();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; instruction = I_LW; aluout = 32'h40;
    mem_rvalid = 1'b0; memdata = '0; flush = 1'b0; out_ready = 1'b0;
    #3;
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst wb_en", 32'(wb_en), 32'd0);
    chk("rst misalign", 32'(misalign), 32'd0);
    chk("rst aluoutM", aluoutM, 32'd0);
    chk("rst instrM", instructionM, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // First cycle after reset release accepts immediately.
    alu_op("add", I_ADD, 32'h0000_0005);

    nxt();
    mem_op("lb", I_LB, 32'h0000_1001, 32'h1234_80FF, 1'b0, 32'hFFFF_FF80, 1'b1);
    mem_op("lbu", I_LBU, 32'h0000_1001, 32'h1234_80FF, 1'b0, 32'h0000_0080, 1'b1);
    mem_op("lhu", I_LHU, 32'h0000_1002, 32'h1234_80FF, 1'b0, 32'h0000_1234, 1'b1);
    mem_op("lh", I_LH, 32'h0000_1000, 32'h1234_80FF, 1'b0, 32'hFFFF_80FF, 1'b1);
    mem_op("lb3", I_LB, 32'h0000_1003, 32'h7F34_80FF, 1'b0, 32'h0000_007F, 1'b1);
    mem_op("lw", I_LW, 32'h0000_1004, 32'h8765_4321, 1'b0, 32'h8765_4321, 1'b1);
    mem_op("sw", I_SW, 32'h0000_0100, 32'h5555_5555, 1'b1, 32'h0000_0100, 1'b0);

    mis_op("lw mis", I_LW, 32'h0000_2002);
    mis_op("lhu mis", I_LHU, 32'h0000_2003);
    alu_op("add clears mis", I_ADD, 32'h0000_0011);
    chk("misalign cleared", 32'(misalign), 32'd0);

    // Flush in WAIT: the late response is drained silently.
    in_valid = 1'b1; instruction = I_LW; aluout = 32'h8;
    nxt(); in_valid = 1'b0; flush = 1'b1;
    nxt(); flush = 1'b0;
    chk("drain busy", 32'(in_ready), 32'd0);
    chk("drain no valid", 32'(out_valid), 32'd0);
    mem_rvalid = 1'b1; memdata = 32'h1111_1111;
    nxt(); mem_rvalid = 1'b0;
    chk("drain idle", 32'(in_ready), 32'd1);
    chk("drain silent", 32'(out_valid), 32'd0);

    // Flush coincident with the response returns straight to IDLE.
    in_valid = 1'b1; instruction = I_LB; aluout = 32'hC;
    nxt(); in_valid = 1'b0; flush = 1'b1; mem_rvalid = 1'b1;
    nxt(); flush = 1'b0; mem_rvalid = 1'b0;
    chk("flush+rvalid idle", 32'(in_ready), 32'd1);
    chk("flush+rvalid no valid", 32'(out_valid), 32'd0);

    // Flush in IDLE blocks acceptance.
    in_valid = 1'b1; instruction = I_LW; aluout = 32'h10; flush = 1'b1;
    #1;
    chk("flush idle no req", 32'(mem_req), 32'd0);
    nxt(); in_valid = 1'b0; flush = 1'b0;
    chk("flush idle stays", 32'(in_ready), 32'd1);
    chk("flush idle no valid", 32'(out_valid), 32'd0);

    // HOLD back-pressure: outputs stable, stray responses ignored.
    in_valid = 1'b1; instruction = I_ADD; aluout = 32'h77; out_ready = 1'b0;
    nxt(); in_valid = 1'b0; aluout = 32'h99;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) out_ready = 1'b1;
      mem_rvalid = (i % 2 == 0); memdata = 32'hA5A5_0000 + 32'(i);
      #1;
      chk("stall out_valid", 32'(out_valid), 32'd1);
      chk("stall aluoutM", aluoutM, 32'h77);
      chk("stall instrM", instructionM, I_ADD);
      chk("stall wb_en", 32'(wb_en), 32'd1);
      nxt();
    end
    mem_rvalid = 1'b0;
    chk("stall release", 32'(out_valid), 32'd0);

    // Flush in HOLD drops the bundle.
    in_valid = 1'b1; instruction = I_ADD; aluout = 32'h3; out_ready = 1'b0;
    nxt(); in_valid = 1'b0; flush = 1'b1;
    chk("hold valid pre-flush", 32'(out_valid), 32'd1);
    nxt(); flush = 1'b0;
    chk("hold flushed", 32'(out_valid), 32'd0);
    chk("hold flushed idle", 32'(in_ready), 32'd1);

    // Response in IDLE is ignored.
    mem_rvalid = 1'b1; memdata = 32'hFFFF_FFFF;
    nxt(); mem_rvalid = 1'b0;
    chk("idle rvalid ignored", 32'(out_valid), 32'd0);
    chk("idle rvalid ready", 32'(in_ready), 32'd1);

    // Reset mid-WAIT abandons the access immediately.
    out_ready = 1'b1;
    in_valid = 1'b1; instruction = I_LW; aluout = 32'h20;
    nxt(); in_valid = 1'b0;
    chk("pre-rst wait", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst async idle", 32'(in_ready), 32'd1);
    chk("rst async instrM", instructionM, 32'd0);
    nxt(); rst = 1'b0;
    mem_rvalid = 1'b1; memdata = 32'h1234_5678;
    nxt(); mem_rvalid = 1'b0;
    chk("post-rst rvalid ignored", 32'(out_valid), 32'd0);
    chk("post-rst idle", 32'(in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
